// File: rtl/snn_pkg.sv
// Shared constants and the loader state encoding for the SNN input path.
package snn_pkg;
    localparam int NUM_PIXELS   = 784;
    localparam int PIX_PER_BYTE = 8;
    localparam int NUM_BYTES    = NUM_PIXELS / PIX_PER_BYTE;
    localparam int DIGIT_W      = 4;
    localparam int ADDR_W       = 10;
    localparam int BCNT_W       = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_WAIT_BYTE,
        ST_START,
        ST_RUN
    } loader_state_t;
endpackage

// File: rtl/snn_input_mem.sv
// 784x1 input-unit memory: one write port, one registered read port.
module snn_input_mem
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic              q
);

    logic mem [NUM_PIXELS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Out-of-range reads return 0 rather than aliasing into the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (raddr < ADDR_W'(NUM_PIXELS)) begin
            q <= mem[raddr];
        end else begin
            q <= 1'b0;
        end
    end

endmodule

// File: rtl/snn_input_loader.sv
// Unpacks a 98-byte image into the input-unit memory, starts the core,
// serves its pixel reads and captures the result digit.
module snn_input_loader
    import snn_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_rdy,
    input  logic [ADDR_W-1:0]  addr_input_unit,
    output logic               q_input,
    output logic               start,
    input  logic               core_done,
    input  logic [DIGIT_W-1:0] core_digit,
    output logic [DIGIT_W-1:0] digit,
    output logic               digit_vld,
    output logic               busy,
    output logic               overrun
);

    loader_state_t     state, state_nxt;
    logic [BCNT_W-1:0] byte_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              accept;
    logic              drop;
    logic              mem_we;
    logic              last_bit;
    logic [ADDR_W-1:0] waddr;

    assign waddr    = {byte_cnt, 3'b000} + {{(ADDR_W-3){1'b0}}, bit_cnt};
    assign last_bit = (bit_cnt == 3'd7);
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = rx_rdy;
                if (rx_rdy) state_nxt = ST_UNPACK;
            end
            ST_UNPACK: begin
                mem_we = 1'b1;
                if (last_bit) begin
                    state_nxt = (byte_cnt == BCNT_W'(NUM_BYTES - 1)) ? ST_START : ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                accept = rx_rdy;
                if (rx_rdy) state_nxt = ST_UNPACK;
            end
            ST_START: state_nxt = ST_RUN;
            ST_RUN: begin
                if (core_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        drop = rx_rdy && !accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            digit     <= '0;
            digit_vld <= 1'b0;
            overrun   <= 1'b0;
            start     <= 1'b0;
        end else begin
            state <= state_nxt;
            start <= (state_nxt == ST_START);
            if (drop) overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (rx_rdy) begin
                        digit_vld <= 1'b0;
                        byte_cnt  <= '0;
                        bit_cnt   <= '0;
                    end
                end
                ST_UNPACK: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (last_bit && (byte_cnt != BCNT_W'(NUM_BYTES - 1))) begin
                        byte_cnt <= byte_cnt + BCNT_W'(1);
                    end
                end
                ST_WAIT_BYTE: begin
                    if (rx_rdy) bit_cnt <= '0;
                end
                ST_RUN: begin
                    if (core_done) begin
                        digit     <= core_digit;
                        digit_vld <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel data path: no reset needed, contents are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift <= rx_data;
        end else if (state == ST_UNPACK) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    snn_input_mem u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (waddr),
        .wdata (shift[0]),
        .raddr (addr_input_unit),
        .q     (q_input)
    );

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed scoreboard bench for snn_input_loader.
module tb_snn_input_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic [9:0] addr_input_unit = 10'd0;
    logic       q_input;
    logic       start;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = 4'd0;
    logic [3:0] digit;
    logic       digit_vld;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int lat;
    bit model [784];
    logic exp_q [$];

    snn_input_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data         (rx_data),
        .rx_rdy          (rx_rdy),
        .addr_input_unit (addr_input_unit),
        .q_input         (q_input),
        .start           (start),
        .core_done       (core_done),
        .core_digit      (core_digit),
        .digit           (digit),
        .digit_vld       (digit_vld),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (start === 1'b1) start_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic load_byte(input int idx, input logic [7:0] b, input int gap);
        for (int k = 0; k < 8; k++) model[idx*8+k] = b[k];
        send(b, gap);
    endtask

    task automatic read_px(input int a);
        logic e;
        @(negedge clk);
        addr_input_unit = 10'(a);
        exp_q.push_back((a < 784) ? logic'(model[a]) : 1'b0);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("q_input[%0d]", a), 16'(q_input), 16'(e));
    endtask

    // Latency in clock edges from the edge that sampled the last rx_rdy.
    task automatic wait_start(output int l);
        l = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (start === 1'b1 && l < 0) l = k;
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_q_input"},   16'(q_input),   16'd0);
        chk({tag, "_start"},     16'(start),     16'd0);
        chk({tag, "_digit"},     16'(digit),     16'd0);
        chk({tag, "_digit_vld"}, 16'(digit_vld), 16'd0);
        chk({tag, "_busy"},      16'(busy),      16'd0);
        chk({tag, "_overrun"},   16'(overrun),   16'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Full load of 0xA5, start latency, reads, RUN isolation
        start_cnt = 0;
        for (int i = 0; i < 97; i++) load_byte(i, 8'hA5, 19);
        load_byte(97, 8'hA5, 0);
        wait_start(lat);
        chk("start_latency", 16'(lat), 16'd8);
        chk("start_count_a", 16'(start_cnt), 16'd1);
        chk("busy_run", 16'(busy), 16'd1);
        for (int a = 0; a < 8; a++) read_px(a);
        read_px(783);
        read_px(800);
        chk("overrun_pre", 16'(overrun), 16'd0);
        send(8'hFF, 2);
        chk("overrun_run", 16'(overrun), 16'd1);
        chk("busy_after_drop", 16'(busy), 16'd1);
        for (int a = 0; a < 8; a++) read_px(a);

        // Result capture
        @(negedge clk);
        core_digit = 4'd7;
        core_done  = 1'b1;
        @(posedge clk);
        #1;
        chk("digit_cap", 16'(digit), 16'd7);
        chk("digit_vld_cap", 16'(digit_vld), 16'd1);
        chk("busy_cap", 16'(busy), 16'd0);
        @(negedge clk);
        core_done = 1'b0;

        // Next image clears digit_vld; reset part-way through
        load_byte(0, 8'h11, 12);
        chk("digit_vld_clr", 16'(digit_vld), 16'd0);
        chk("digit_hold", 16'(digit), 16'd7);
        for (int i = 1; i < 50; i++) load_byte(i, 8'(i * 3), 12);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh load with a back-to-back byte at position 0
        start_cnt = 0;
        for (int k = 0; k < 8; k++) model[k] = bit'(8'h3C >> k);
        @(negedge clk);
        rx_data = 8'h3C;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_data = 8'hFF;
        @(negedge clk);
        rx_rdy  = 1'b0;
        chk("overrun_b2b", 16'(overrun), 16'd1);
        repeat (10) @(negedge clk);
        for (int i = 1; i < 97; i++) load_byte(i, 8'(i * 37 + 5), 10);
        load_byte(97, 8'(97 * 37 + 5), 0);
        wait_start(lat);
        chk("start_latency_b", 16'(lat), 16'd8);
        chk("start_count_b", 16'(start_cnt), 16'd1);
        for (int a = 0; a < 16; a++) read_px(a);
        for (int a = 400; a < 408; a++) read_px(a);
        for (int a = 776; a < 784; a++) read_px(a);

        // Coincident rx_rdy and core_done in RUN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("overrun_cleared", 16'(overrun), 16'd0);
        for (int i = 0; i < 97; i++) load_byte(i, 8'(i) ^ 8'h5A, 9);
        load_byte(97, 8'd97 ^ 8'h5A, 0);
        wait_start(lat);
        chk("start_latency_c", 16'(lat), 16'd8);
        @(negedge clk);
        core_digit = 4'd3;
        core_done  = 1'b1;
        rx_data    = 8'h00;
        rx_rdy     = 1'b1;
        @(posedge clk);
        #1;
        chk("digit_coinc", 16'(digit), 16'd3);
        chk("digit_vld_coinc", 16'(digit_vld), 16'd1);
        chk("overrun_coinc", 16'(overrun), 16'd1);
        chk("busy_coinc", 16'(busy), 16'd0);
        @(negedge clk);
        core_done = 1'b0;
        rx_rdy    = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_idle", 16'(busy), 16'd0);
        for (int a = 0; a < 8; a++) read_px(a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
